// File: rtl/c1_bus_pkg.sv
// rtl/c1_bus_pkg.sv - bus-1 (A1/D1/C1) command codes, sizes and arbiter state encoding
package c1_bus_pkg;

  localparam int ADDR1_BUS_SIZE    = 15;
  localparam int DATA_BUS_SIZE     = 16;
  localparam int CTR1_BUS_SIZE     = 3;
  localparam int CACHE_ADDR_SIZE   = 19;
  localparam int CACHE_OFFSET_SIZE = 4;

  typedef logic [CTR1_BUS_SIZE-1:0] c1_cmd_t;

  // Eight codes for nine names: NOP and RESPONSE share 0, neither is ever issued by a requester.
  localparam c1_cmd_t C1_NOP             = 3'd0;
  localparam c1_cmd_t C1_RESPONSE        = 3'd0;
  localparam c1_cmd_t C1_READ8           = 3'd1;
  localparam c1_cmd_t C1_READ16          = 3'd2;
  localparam c1_cmd_t C1_READ32          = 3'd3;
  localparam c1_cmd_t C1_INVALIDATE_LINE = 3'd4;
  localparam c1_cmd_t C1_WRITE8          = 3'd5;
  localparam c1_cmd_t C1_WRITE16         = 3'd6;
  localparam c1_cmd_t C1_WRITE32         = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR1,
    ST_ADDR2,
    ST_WAIT,
    ST_RESP2,
    ST_ABORT
  } arb_state_t;

  function automatic logic c1_cmd_legal(input c1_cmd_t c);
    case (c)
      C1_READ8, C1_READ16, C1_READ32,
      C1_WRITE8, C1_WRITE16, C1_WRITE32,
      C1_INVALIDATE_LINE: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic c1_cmd_is_write(input c1_cmd_t c);
    return (c == C1_WRITE8) || (c == C1_WRITE16) || (c == C1_WRITE32);
  endfunction

endpackage

// File: rtl/c1_bus_arbiter_rr_arb2.sv
// rtl/c1_bus_arbiter_rr_arb2.sv - two-way round-robin pick
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       winner,
  output logic       valid,
  output logic       next_ptr
);

  always_comb begin
    valid  = |req;
    winner = rr_ptr;
    if (req == 2'b01) begin
      winner = 1'b0;
    end else if (req == 2'b10) begin
      winner = 1'b1;
    end
    next_ptr = ~winner;
  end

endmodule

// File: rtl/c1_bus_arbiter.sv
// rtl/c1_bus_arbiter.sv - shares bus-1 between two requesters and runs the
// command/address/wait/response sequence for the round-robin winner
module c1_bus_arbiter
  import c1_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [1:0]                       req,
  input  logic [1:0][CTR1_BUS_SIZE-1:0]    cmd,
  input  logic [1:0][CACHE_ADDR_SIZE-1:0]  addr,
  input  logic [1:0][31:0]                 wdata,
  output logic [1:0]                       gnt,
  output logic [1:0]                       done,
  output logic [1:0]                       err,
  output logic [1:0][31:0]                 rdata,
  inout  wire  [ADDR1_BUS_SIZE-1:0]        a1,
  inout  wire  [DATA_BUS_SIZE-1:0]         d1,
  inout  wire  [CTR1_BUS_SIZE-1:0]         c1
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t                  state_q, state_d;
  logic                        owner_q;
  c1_cmd_t                     cmd_q;
  logic [CACHE_ADDR_SIZE-1:0]  addr_q;
  logic [31:0]                 wdata_q;
  logic [15:0]                 rd_lo_q;
  logic                        rr_ptr_q;
  logic [CNT_W-1:0]            wait_cnt_q;

  logic arb_winner, arb_valid, arb_next_ptr;
  logic resp_seen, timeout_hit;

  logic [ADDR1_BUS_SIZE-1:0] a1_drv;
  logic [DATA_BUS_SIZE-1:0]  d1_drv;
  c1_cmd_t                   c1_drv;
  logic                      a1_oe, d1_oe, c1_oe;

  rr_arb2 u_rr_arb2 (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .winner   (arb_winner),
    .valid    (arb_valid),
    .next_ptr (arb_next_ptr)
  );

  assign resp_seen   = (c1 == C1_RESPONSE);
  // The counter has already seen CNT_LAST cycles, so this WAIT cycle is the last one allowed.
  assign timeout_hit = (wait_cnt_q == CNT_LAST);

  assign a1 = a1_oe ? a1_drv : 'z;
  assign d1 = d1_oe ? d1_drv : 'z;
  assign c1 = c1_oe ? c1_drv : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      cmd_q      <= C1_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_lo_q    <= '0;
      rr_ptr_q   <= 1'b0;
      wait_cnt_q <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      rdata      <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            owner_q         <= arb_winner;
            cmd_q           <= cmd[arb_winner];
            addr_q          <= addr[arb_winner];
            wdata_q         <= wdata[arb_winner];
            rr_ptr_q        <= arb_next_ptr;
            wait_cnt_q      <= '0;
            gnt[arb_winner] <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q != CNT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
          if (resp_seen) begin
            case (cmd_q)
              C1_READ8:  rdata[owner_q] <= {24'b0, d1[7:0]};
              C1_READ16: rdata[owner_q] <= {16'b0, d1};
              C1_READ32: rd_lo_q        <= d1;
              default:   ;
            endcase
            if (cmd_q != C1_READ32) done[owner_q] <= 1'b1;
          end
        end
        ST_RESP2: begin
          rdata[owner_q] <= {d1, rd_lo_q};
          done[owner_q]  <= 1'b1;
        end
        ST_ABORT: err[owner_q] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) state_d = c1_cmd_legal(cmd[arb_winner]) ? ST_ADDR1 : ST_ABORT;
      end
      ST_ADDR1: state_d = ST_ADDR2;
      ST_ADDR2: state_d = ST_WAIT;
      ST_WAIT: begin
        if (resp_seen)        state_d = (cmd_q == C1_READ32) ? ST_RESP2 : ST_IDLE;
        else if (timeout_hit) state_d = ST_ABORT;
      end
      ST_RESP2: state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a1_oe  = 1'b0;
    d1_oe  = 1'b0;
    c1_oe  = 1'b0;
    a1_drv = '0;
    d1_drv = '0;
    c1_drv = cmd_q;
    case (state_q)
      ST_ADDR1: begin
        c1_oe  = 1'b1;
        a1_oe  = 1'b1;
        a1_drv = addr_q[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
        d1_oe  = c1_cmd_is_write(cmd_q);
        d1_drv = wdata_q[15:0];
      end
      ST_ADDR2: begin
        c1_oe  = 1'b1;
        a1_oe  = 1'b1;
        a1_drv = ADDR1_BUS_SIZE'(addr_q[CACHE_OFFSET_SIZE-1:0]);
        d1_oe  = (cmd_q == C1_WRITE32);
        d1_drv = wdata_q[31:16];
      end
      default: ;
    endcase
  end

endmodule
